// File: rtl/p2s_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// p2s_tx_scheduler_if
// Bundles the requester-facing and serializer-facing signals of
// p2s_tx_scheduler.
//
//   req          requester -> scheduler  per-requester request level
//   din_bus      requester -> scheduler  word of requester i at [i*W +: W]
//   lngt_bus     requester -> scheduler  bit length of requester i at [i*BL +: BL]
//   ack          scheduler -> requester  one-cycle pulse, word i captured
//   done         scheduler -> requester  one-cycle pulse, frame i finished
//   busy         scheduler -> requester  scheduler is not idle
//   ser_dv       scheduler -> serializer dv_in pulse
//   ser_din      scheduler -> serializer parallel word
//   ser_bit_lngt scheduler -> serializer bit length
//
// Handshake: a requester raises req[i] and holds req[i], its word and its
// length stable until it sees ack[i] high. The word is taken on the edge that
// raises ack[i]. Dropping req[i] before ack[i] withdraws the request; keeping
// req[i] high after ack[i] is a new request. ser_dv is a single-cycle
// strobe with no back-pressure: ser_din/ser_bit_lngt are valid while it is
// high and keep their values until the next strobe.
//
// The master modport is the requester side; the slave modport is the
// scheduler.
// ----------------------------------------------------------------------------
interface p2s_tx_scheduler_if #(
  parameter int PARALLEL_PORT_WIDTH = 14,
  parameter int BIT_LENGTH          = 4,
  parameter int N_REQ               = 2
) ();

  logic [N_REQ-1:0]                     req;
  logic [N_REQ*PARALLEL_PORT_WIDTH-1:0] din_bus;
  logic [N_REQ*BIT_LENGTH-1:0]          lngt_bus;
  logic [N_REQ-1:0]                     ack;
  logic [N_REQ-1:0]                     done;
  logic                                 busy;
  logic                                 ser_dv;
  logic [PARALLEL_PORT_WIDTH-1:0]       ser_din;
  logic [BIT_LENGTH-1:0]                ser_bit_lngt;

  modport master (
    output req, din_bus, lngt_bus,
    input  ack, done, busy, ser_dv, ser_din, ser_bit_lngt
  );

  modport slave (
    input  req, din_bus, lngt_bus,
    output ack, done, busy, ser_dv, ser_din, ser_bit_lngt
  );

endinterface

// File: rtl/p2s_tx_scheduler.sv
// ----------------------------------------------------------------------------
// p2s_tx_scheduler
// Round-robin scheduler sharing one parallel_serial serializer between N_REQ
// requesters. In IDLE it grants the first requesting index at or after the
// round-robin pointer, captures that requester's word and effective length,
// strobes the serializer, then waits out the shift duration (SHIFT) and an
// optional inter-frame gap (GAP) before arbitrating again.
//
// Ports:
//   clk      in   clock, rising edge
//   rstn     in   asynchronous active-low reset
//   bus      slave modport of p2s_tx_scheduler_if (requesters + serializer)
//   state_o  out  current FSM state (IDLE=0, SHIFT=1, GAP=2) for observation
// ----------------------------------------------------------------------------
module p2s_tx_scheduler #(
  parameter int PARALLEL_PORT_WIDTH = 14,
  parameter int BIT_LENGTH          = 4,
  parameter int N_REQ               = 2,
  parameter int GAP_CYCLES          = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  p2s_tx_scheduler_if.slave        bus,
  output logic [1:0]               state_o
);

  localparam int W       = PARALLEL_PORT_WIDTH;
  localparam int BL      = BIT_LENGTH;
  localparam int PW      = $clog2(N_REQ);
  // Counter holds either a frame length (<= W) or the gap length.
  localparam int CNT_MAX = (W > GAP_CYCLES) ? W : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             dv_q, dv_d;
  logic [W-1:0]     din_q, din_d;
  logic [BL-1:0]    lngt_q, lngt_d;

  // Round-robin search starting at ptr_q.
  logic          grant_vld;
  logic [PW-1:0] grant_idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_vld && bus.req[(int'(ptr_q) + k) % N_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = PW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  // Effective length of the candidate word: 0 or anything beyond the word
  // width means "send the whole word".
  logic [BL-1:0] raw_lngt;
  logic [BL-1:0] eff_lngt;

  always_comb begin
    raw_lngt = bus.lngt_bus[int'(grant_idx)*BL +: BL];
    if (raw_lngt == '0 || int'(raw_lngt) > W) begin
      eff_lngt = BL'(W);
    end else begin
      eff_lngt = raw_lngt;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    done_d  = '0;
    dv_d    = 1'b0;
    din_d   = din_q;
    lngt_d  = lngt_q;

    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          din_d           = bus.din_bus[int'(grant_idx)*W +: W];
          lngt_d          = eff_lngt;
          cnt_d           = CW'(eff_lngt);
          dv_d            = 1'b1;
          ack_d[grant_idx] = 1'b1;
          owner_d         = grant_idx;
          ptr_d           = PW'((int'(grant_idx) + 1) % N_REQ);
          state_d         = SHIFT;
        end
      end

      SHIFT: begin
        // cnt_q == 1 here is the last serializer shift cycle of the frame.
        if (cnt_q == CW'(1)) begin
          done_d[owner_q] = 1'b1;
          if (GAP_CYCLES == 0) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = CW'(GAP_CYCLES);
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      GAP: begin
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      dv_q    <= 1'b0;
      din_q   <= '0;
      lngt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      dv_q    <= dv_d;
      din_q   <= din_d;
      lngt_q  <= lngt_d;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.done         = done_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.ser_dv       = dv_q;
  assign bus.ser_din      = din_q;
  assign bus.ser_bit_lngt = lngt_q;
  assign state_o          = state_q;

endmodule

// File: doc/p2s_tx_scheduler.md
# p2s_tx_scheduler

Round-robin scheduler that shares one `parallel_serial` serializer between `N_REQ` requesters on the bus transmit side. It accepts parallel words with per-request bit lengths and drives the serializer's `dv_in`/`din`/`bit_lngt` inputs one frame at a time. It tracks each frame's shift duration, inserts a configurable inter-frame gap, and reports per-requester acknowledge and completion.

## Interface
- `PARALLEL_PORT_WIDTH`, 14: serializer parallel word width (W).
- `BIT_LENGTH`, 4: width of the bit-length field (BL).
- `N_REQ`, 2: number of requesters, at least 2.
- `GAP_CYCLES`, 2: idle cycles after each frame; 0 is allowed.
- `clk` in 1: single clock; all logic on rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `req` in N_REQ: per-requester request level.
- `din_bus` in N_REQ*W: requester i word at bits [i*W +: W].
- `lngt_bus` in N_REQ*BL: requester i bit length at bits [i*BL +: BL].
- `ack` out N_REQ: one-cycle pulse when requester i's word is captured.
- `done` out N_REQ: one-cycle pulse when requester i's frame has finished shifting.
- `busy` out 1: high whenever state is not IDLE.
- `ser_dv` out 1: to serializer `dv_in`; one-cycle pulse.
- `ser_din` out W: to serializer `din`.
- `ser_bit_lngt` out BL: to serializer `bit_lngt`.

## Operation
- States: IDLE, SHIFT, GAP. Everything is registered.
- Round-robin pointer `ptr`:
  - Reset value is 0.
  - In IDLE, the winner is the first asserted `req[k]` searching k = ptr, ptr+1, … (mod N_REQ).
  - After a grant to i, `ptr` becomes (i+1) mod N_REQ.
- Grant edge, in IDLE with any `req` high:
  - Capture `din_bus[i]` into `ser_din`.
  - Capture the effective length L into `ser_bit_lngt` and the counter.
  - Set `ser_dv`=1 and `ack[i]`=1 for the following cycle only.
  - Record owner = i and go to SHIFT.
- Length rule: L = raw length, except raw = 0 or raw > W is clamped to W.
- SHIFT: the counter decrements each edge. On the edge where the counter is 1:
  - Pulse `done[owner]`.
  - Load the counter with GAP_CYCLES and go to GAP, or go to IDLE if GAP_CYCLES = 0.
- GAP: the counter decrements each edge; on the edge where it is 1, go to IDLE.
- Handshake rules:
  - A requester holds `req`, its word and its length stable until it sees `ack`.
  - `req` dropped before `ack` means the request is not served.
  - `req` still high after `ack` is treated as a new request.
- `req` changes during SHIFT and GAP are ignored; arbitration happens only in IDLE.
- `ser_din` and `ser_bit_lngt` hold their values until the next grant.
- Reset (asynchronous, including mid-frame):
  - Go to IDLE, set `ptr`=0, clear the counter.
  - All outputs go to 0.
  - An aborted frame produces no `done`.

## Timing
- Grant edge E0:
  - `ack[i]` and `ser_dv` are high during cycle E0→E0+1.
  - `busy` rises at E0.
- `done[i]` is high during cycle E0+L → E0+L+1.
- `busy` falls at E0+L+GAP_CYCLES.
- Minimum spacing between consecutive `ser_dv` pulses is L+GAP_CYCLES+1 cycles, because one IDLE cycle is needed to arbitrate.
- Request-to-ack latency from IDLE is 1 cycle: `req` sampled at edge E0, `ack` high after E0.
- `ack` and `done` are one-hot at all times. They never overlap for the same requester unless L = 1 and the requester re-requests, which is impossible because IDLE precedes every grant.

## Test plan
Conditions: W=14, BL=4, N_REQ=2, GAP_CYCLES=2.

- **Single frame.** req0 with din=9, lngt=14.
  - Required: one `ser_dv` cycle with `ser_din`=9 and `ser_bit_lngt`=14.
  - `ack[0]` in the same cycle.
  - `done[0]` 14 cycles after `ack[0]`.
  - `busy` high for 16 cycles.
- **Simultaneous requests.** req0 din=9 and req1 din=12 together, both lngt=14.
  - Required: req0 is served first.
  - `ack[1]` and a `ser_dv` with `ser_din`=12 exactly 17 cycles after `ack[0]`.
- **Fairness.** req0 and req1 held high continuously for 6 frames.
  - Required: grants alternate 0,1,0,1,0,1.
  - No two `ser_dv` pulses are closer than 17 cycles.
- **Length clamp.** lngt=0, then lngt=15, then lngt=3.
  - Required: `ser_bit_lngt`=14 with `done` 14 cycles after `ack`.
  - Then 14 with `done` after 14 cycles.
  - Then 3 with `done` 3 cycles after `ack`.
- **Mid-frame request.** req1 raised 5 cycles into req0's frame.
  - Required: no `ack[1]` until req0's `done` + GAP + 1 IDLE cycle.
  - `ser_din` unchanged throughout req0's frame.
- **Reset mid-SHIFT.** Deassert `rstn` 6 cycles after `ack[0]`.
  - Required: all outputs are 0 immediately (asynchronous).
  - No `done[0]`.
  - After release, a simultaneous req0/req1 grants req0 first (`ptr`=0).
